// File: rtl/ahb_slave_mux_if.sv
// AHB-Lite data-phase bundle between the address decoder, the slave ports and
// the master, as seen by the response multiplexer.
interface ahb_slave_mux_if #(
  parameter int NSLV = 2,
  parameter int DW   = 32
);
  logic [NSLV-1:0]    HSEL;
  logic [1:0]         HTRANS;
  logic [NSLV-1:0]    HREADYOUT_S;
  logic [NSLV-1:0]    HRESP_S;
  logic [NSLV*DW-1:0] HRDATA_S;
  logic               HREADY;
  logic               HRESP;
  logic [DW-1:0]      HRDATA;

  modport slave (
    input  HSEL, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
    output HREADY, HRESP, HRDATA
  );

  modport master (
    output HSEL, HTRANS, HREADYOUT_S, HRESP_S, HRDATA_S,
    input  HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_slave_mux.sv
// AHB-Lite slave-response multiplexer with built-in default slave and a
// wait-state watchdog that turns long stalls into two-cycle ERROR responses.
//
// state | meaning
// PASS  | route captured slave (or idle OKAY); DEF_ERR/abort drive ERR1 here
// ERR1  | first ERROR cycle: HREADY=0, HRESP=1
// ERR2  | second ERROR cycle: HREADY=1, HRESP=1, next address captured
module ahb_slave_mux #(
  parameter int NSLV    = 2,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  ahb_slave_mux_if.slave  bus,
  output logic            TO_ABORT,
  output logic [CNTW-1:0] ERR_CNT
);

  localparam int IW  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {PASS, ERR1, ERR2} state_t;
  typedef enum logic [1:0] {D_NONE, D_SLV, D_ERR} dkind_t;

  state_t         state, state_nxt;
  dkind_t         dkind, dkind_nxt;
  logic [IW-1:0]  dsel_idx, dsel_idx_nxt;
  logic [WCW-1:0] wcnt;
  logic [4:0]     nbits;
  logic           hready, hresp, abort;
  logic           slv_ready, slv_resp;
  logic [DW-1:0]  slv_data, hrdata;
  logic           unused_htrans0;

  assign unused_htrans0 = bus.HTRANS[0];

  // Address-phase decode: one-hot select vs. unmapped/multiply-decoded access
  always_comb begin
    nbits        = '0;
    dsel_idx_nxt = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (bus.HSEL[i]) begin
        nbits        = nbits + 5'd1;
        dsel_idx_nxt = IW'(i);
      end
    end
    if (!bus.HTRANS[1])
      dkind_nxt = D_NONE;
    else if (nbits == 5'd1)
      dkind_nxt = D_SLV;
    else
      dkind_nxt = D_ERR;
  end

  always_comb begin
    slv_ready = 1'b1;
    slv_resp  = 1'b0;
    slv_data  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (dsel_idx == IW'(i)) begin
        slv_ready = bus.HREADYOUT_S[i];
        slv_resp  = bus.HRESP_S[i];
        slv_data  = bus.HRDATA_S[i*DW +: DW];
      end
    end
  end

  assign abort = (TIMEOUT > 0) && (state == PASS) && (dkind == D_SLV) &&
                 (wcnt == WCW'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    hready    = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    case (state)
      PASS: begin
        if (dkind == D_ERR || abort) begin
          hready    = 1'b0;
          hresp     = 1'b1;
          state_nxt = ERR2;
        end else if (dkind == D_SLV) begin
          hready = slv_ready;
          hresp  = slv_resp;
          hrdata = slv_data;
        end
      end
      ERR1: begin
        hready    = 1'b0;
        hresp     = 1'b1;
        state_nxt = ERR2;
      end
      ERR2: begin
        hresp     = 1'b1;
        state_nxt = PASS;
      end
      default: state_nxt = PASS;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= PASS;
      dkind    <= D_NONE;
      dsel_idx <= '0;
      wcnt     <= '0;
      ERR_CNT  <= '0;
    end else begin
      state <= state_nxt;
      if (hready) begin
        dkind    <= dkind_nxt;
        dsel_idx <= dsel_idx_nxt;
      end
      // Watchdog only runs while the selected slave itself is stalling
      if (hready || abort)
        wcnt <= '0;
      else if (state == PASS && dkind == D_SLV && wcnt != WCW'(TIMEOUT))
        wcnt <= wcnt + WCW'(1);
      if (state == ERR2 && ERR_CNT != '1)
        ERR_CNT <= ERR_CNT + CNTW'(1);
    end
  end

  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;
  assign bus.HRDATA = hrdata;
  assign TO_ABORT   = abort;

endmodule

// File: doc/ahb_slave_mux.md
# ahb_slave_mux

Parametrised AHB-Lite slave-response multiplexer and default slave for the Tiny_SoC bus fabric. It sits between the address decoder and the master. It captures the one-hot slave select in the address phase and qualifies that capture with HREADY. In the data phase it routes the selected slave's HREADYOUT/HRDATA/HRESP to the master. It also generates two-cycle ERROR responses for unmapped or multiply-decoded accesses and for slaves that stall past a programmable timeout.

## Interface
Parameters:
- NSLV, 2, number of slave ports (1..16)
- DW, 32, data width
- TIMEOUT, 255, max wait-state cycles before abort; 0 disables the watchdog
- CNTW, 8, width of the saturating error counter

Ports:
- clk  in  1  bus clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- HSEL  in  NSLV  one-hot address-phase select from decoder
- HTRANS  in  2  master transfer type; bit 1 set means NONSEQ/SEQ
- HREADYOUT_S  in  NSLV  per-slave ready, bit i = slave i
- HRESP_S  in  NSLV  per-slave response, 1 = ERROR
- HRDATA_S  in  NSLV*DW  per-slave read data, slave i at [i*DW +: DW]
- HREADY  out  1  ready to master and to all slaves
- HRESP  out  1  response to master
- HRDATA  out  DW  read data to master
- TO_ABORT  out  1  one-cycle pulse when the watchdog aborts a transfer
- ERR_CNT  out  CNTW  saturating count of mux-generated ERROR responses

## Operation
- Address-phase capture: on each rising edge with HREADY=1, register dsel, which is one of: slave i (HSEL one-hot, bit i), DEF_ERR, or NONE. With HREADY=0, dsel holds.
- DEF_ERR is captured when HTRANS[1]=1 and HSEL is zero or has more than one bit set.
- NONE is captured when HTRANS[1]=0, or when HSEL=0 with HTRANS IDLE/BUSY.
- FSM states are PASS, ERR1 and ERR2. Reset enters PASS.
- PASS with dsel=slave i: HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i], HRDATA=slice i. Slave ERROR responses pass through unmodified and are not counted.
- PASS with dsel=NONE: HREADY=1, HRESP=0, HRDATA=0. This is a zero-wait OKAY.
- PASS with dsel=DEF_ERR: outputs are driven combinationally as ERR1 in that same cycle. The FSM then moves to ERR2 on the next edge.
- ERR1: HREADY=0, HRESP=1, HRDATA=0.
- ERR2: HREADY=1, HRESP=1, HRDATA=0. The next edge returns to PASS, increments ERR_CNT (saturating at all-ones), and captures the next address phase.
- Watchdog: wcnt counts edges while in PASS with dsel=slave i and HREADYOUT_S[i]=0. It clears whenever HREADY=1.
- When wcnt reaches TIMEOUT (TIMEOUT>0), the mux ignores the slave and drives the ERR1 response in that cycle. TO_ABORT=1 for that cycle, then the FSM goes to ERR2.
- Any later response from the aborted slave is ignored. The master is responsible for the aborted transfer.
- Only HREADYOUT of the selected slave matters. Unselected slaves' outputs never reach the master.

## Timing
- Reset values: dsel=NONE, state=PASS, wcnt=0, ERR_CNT=0, TO_ABORT=0. Outputs during and after reset are HREADY=1, HRESP=0, HRDATA=0.
- Data-phase outputs are combinational from registered dsel/state plus slave inputs. Latency from slave to master is zero cycles.
- Select capture latency: HSEL in address cycle n governs outputs in cycle n+1 onward.
- An ERROR response always lasts exactly 2 cycles: HRESP=1 in both, HREADY low then high.
- The address phase presented during ERR2 is captured, per AHB-Lite. The master may drive IDLE there to cancel.
- Back-to-back decode errors give 2-cycle ERROR sequences with no OKAY cycle in between.
- Timeout abort: with TIMEOUT=T, a stalled slave gives T cycles of HREADY=0 from the slave, then 1 mux ERR1 cycle, then ERR2. That is T+1 low cycles in total.
- Asserting reset mid-transfer, including during ERR1/ERR2, immediately forces the reset values. No partial error is counted.

## Test plan
- Reset, then NONSEQ to slave 1 (NSLV=4) with HREADYOUT_S[1] low 2 cycles and HRDATA slice 1=0xA5A5_0001 -> HREADY low 2 cycles then high, HRDATA=0xA5A5_0001, HRESP=0.
- NONSEQ with HSEL=0, then NONSEQ with HSEL=4'b0110 -> two back-to-back 2-cycle ERROR sequences (HREADY 0,1,0,1; HRESP 1,1,1,1), ERR_CNT=2.
- IDLE transfer with HSEL=0 -> HREADY=1, HRESP=0 in the data phase, ERR_CNT unchanged.
- TIMEOUT=4, selected slave holds HREADYOUT low indefinitely -> 4 slave-stall cycles, TO_ABORT pulse with HRESP=1/HREADY=0, then HRESP=1/HREADY=1, ERR_CNT+1.
- Slave holds HREADY low while decoder HSEL changes -> dsel unchanged until HREADY=1. Output stays on the original slave.
- Assert reset during ERR1 -> HREADY=1, HRESP=0 immediately, ERR_CNT=0. First transfer after release behaves normally.
